// File: rtl/write_bpm_test_link_if.sv
// rtl/write_bpm_test_link_if.sv - AXI4-Stream TX bundle for the BPM test link
interface write_bpm_test_link_if;
  logic [31:0] tdata;
  logic        tvalid;
  logic        tlast;
  logic        tready;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/write_bpm_test_link.sv
// rtl/write_bpm_test_link.sv - FA-strobed BPM test packet generator on an Aurora TX stream
// Optional WRITE_BPM_TEST_LINK_LFSR_EN: X word from a 32-bit Galois LFSR instead of the sample ramp.
module write_bpm_test_link #(
  parameter int          BPM_COUNT = 2,
  parameter logic [15:0] MAGIC     = 16'hA5BE
) (
  input  logic                         auroraUserClk,
  input  logic                         auroraReset,
  input  logic                         auroraFAstrobe,
  input  logic                         auroraChannelUp,
  write_bpm_test_link_if.master        BPM_TEST_AXI_STREAM_TX
);

  typedef enum logic {IDLE, SEND} state_t;

  localparam logic [9:0] LAST_BPM = 10'(BPM_COUNT - 1);

  state_t      state_q, state_d;
  logic [9:0]  bpm_index_q, bpm_index_d;
  logic [1:0]  word_index_q, word_index_d;
  logic [31:0] sample_count_q, sample_count_d;
  logic [31:0] x_word;
  logic [31:0] word_data;

`ifdef WRITE_BPM_TEST_LINK_LFSR_EN
  logic [31:0] lfsr_q, lfsr_d;
  logic [31:0] lfsr_next;

  // Right-shifting Galois form of x^32+x^22+x^2+x+1
  assign lfsr_next = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? 32'h8020_0003 : 32'h0);
  assign x_word    = lfsr_q;
`else
  assign x_word    = sample_count_q;
`endif

  always_ff @(posedge auroraUserClk) begin
    if (auroraReset) begin
      state_q        <= IDLE;
      bpm_index_q    <= '0;
      word_index_q   <= '0;
      sample_count_q <= '0;
`ifdef WRITE_BPM_TEST_LINK_LFSR_EN
      lfsr_q         <= 32'h1;
`endif
    end else begin
      state_q        <= state_d;
      bpm_index_q    <= bpm_index_d;
      word_index_q   <= word_index_d;
      sample_count_q <= sample_count_d;
`ifdef WRITE_BPM_TEST_LINK_LFSR_EN
      lfsr_q         <= lfsr_d;
`endif
    end
  end

  always_comb begin
    state_d        = state_q;
    bpm_index_d    = bpm_index_q;
    word_index_d   = word_index_q;
    sample_count_d = sample_count_q;
`ifdef WRITE_BPM_TEST_LINK_LFSR_EN
    lfsr_d         = lfsr_q;
`endif
    case (state_q)
      IDLE: begin
        if (auroraFAstrobe && auroraChannelUp) begin
          state_d      = SEND;
          bpm_index_d  = '0;
          word_index_d = '0;
        end
      end
      SEND: begin
        // A completed or aborted burst both retire the current sample number
        if (!auroraChannelUp ||
            (BPM_TEST_AXI_STREAM_TX.tready && word_index_q == 2'd3 && bpm_index_q == LAST_BPM)) begin
          state_d        = IDLE;
          bpm_index_d    = '0;
          word_index_d   = '0;
          sample_count_d = sample_count_q + 32'd1;
`ifdef WRITE_BPM_TEST_LINK_LFSR_EN
          lfsr_d         = lfsr_next;
`endif
        end else if (BPM_TEST_AXI_STREAM_TX.tready) begin
          word_index_d = word_index_q + 2'd1;
          if (word_index_q == 2'd3) begin
            bpm_index_d = bpm_index_q + 10'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    word_data = '0;
    case (word_index_q)
      2'd0: word_data = {MAGIC, 6'b0, bpm_index_q};
      2'd1: word_data = x_word;
      2'd2: word_data = ~x_word;
      2'd3: word_data = {bpm_index_q, sample_count_q[21:0]};
      default: word_data = '0;
    endcase
  end

  assign BPM_TEST_AXI_STREAM_TX.tvalid = (state_q == SEND);
  assign BPM_TEST_AXI_STREAM_TX.tdata  = (state_q == SEND) ? word_data : 32'h0;
  assign BPM_TEST_AXI_STREAM_TX.tlast  = (state_q == SEND) && (word_index_q == 2'd3);

endmodule

// File: tb/tb_write_bpm_test_link.sv
// tb/tb_write_bpm_test_link.sv - self-checking bench for write_bpm_test_link
module tb_write_bpm_test_link;

  localparam int N_BPM = 2;

  logic clk;
  logic rst;
  logic strobe;
  logic chup;
  logic tready_r;
  logic rand_rdy;

  write_bpm_test_link_if bus ();
  assign bus.tready = tready_r;

  write_bpm_test_link #(.BPM_COUNT(N_BPM), .MAGIC(16'hA5BE)) dut (
    .auroraUserClk          (clk),
    .auroraReset            (rst),
    .auroraFAstrobe         (strobe),
    .auroraChannelUp        (chup),
    .BPM_TEST_AXI_STREAM_TX (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  // Reference model: queue of the words the current burst must still deliver
  logic [31:0] exp_d[$];
  logic        exp_l[$];
  bit          busy;
  logic [31:0] m_sample;
  logic [31:0] m_lfsr;

  function automatic logic [31:0] galois(input logic [31:0] v);
    logic [31:0] r;
    r = v >> 1;
    if (v[0]) r = r ^ 32'h8020_0003;
    return r;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      exp_d.delete();
      exp_l.delete();
      busy = 0;
      m_sample = 0;
      m_lfsr = 32'h1;
    end else if (busy) begin
      if (!chup || (tready_r && exp_d.size() == 1)) begin
        exp_d.delete();
        exp_l.delete();
        busy = 0;
        m_sample = m_sample + 1;
        m_lfsr = galois(m_lfsr);
      end else if (tready_r) begin
        void'(exp_d.pop_front());
        void'(exp_l.pop_front());
      end
    end else if (strobe && chup) begin
      logic [31:0] x;
`ifdef WRITE_BPM_TEST_LINK_LFSR_EN
      x = m_lfsr;
`else
      x = m_sample;
`endif
      for (int b = 0; b < N_BPM; b++) begin
        exp_d.push_back(32'hA5BE_0000 + b);                   exp_l.push_back(1'b0);
        exp_d.push_back(x);                                   exp_l.push_back(1'b0);
        exp_d.push_back(32'hFFFF_FFFF - x);                   exp_l.push_back(1'b0);
        exp_d.push_back((b << 22) | (m_sample & 32'h3F_FFFF)); exp_l.push_back(1'b1);
      end
      busy = 1;
    end
  end

  // Per-cycle compare, transfer log and hold check, all away from the clock edge
  logic [31:0] log_d[$];
  logic        log_l[$];
  bit          hold_prev;
  logic [31:0] hold_data;

  always @(negedge clk) begin
    if (!rst) begin
      check("tvalid", {31'b0, bus.tvalid}, {31'b0, busy});
      if (busy) begin
        check("tdata", bus.tdata, exp_d[0]);
        check("tlast", {31'b0, bus.tlast}, {31'b0, exp_l[0]});
      end else begin
        check("tlast_idle", {31'b0, bus.tlast}, 32'h0);
      end
      if (hold_prev && bus.tvalid) check("hold_tdata", bus.tdata, hold_data);
      if (bus.tvalid && tready_r) begin
        log_d.push_back(bus.tdata);
        log_l.push_back(bus.tlast);
      end
      hold_prev = bus.tvalid && !tready_r;
      hold_data = bus.tdata;
    end else begin
      hold_prev = 0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    if (rand_rdy) tready_r = 1'($urandom_range(0, 1));
  endtask

  task automatic pulse();
    strobe = 1'b1;
    step();
    strobe = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (busy && n < budget) begin
      step();
      n++;
    end
    if (busy) begin
      n_cmp++;
      n_bad++;
      $display("FAIL wait_idle timeout actual=busy required=idle");
    end
  endtask

  task automatic clear_log();
    log_d.delete();
    log_l.delete();
  endtask

  logic [31:0] lit1 [8];
  int          nlast;

  initial begin
    rst = 1'b1; strobe = 1'b0; chup = 1'b0; tready_r = 1'b1; rand_rdy = 1'b0;
    hold_prev = 0;
    repeat (3) step();
    rst = 1'b0;
    step();
    check("reset_tvalid", {31'b0, bus.tvalid}, 32'h0);
    check("reset_tdata", bus.tdata, 32'h0);
    check("reset_tlast", {31'b0, bus.tlast}, 32'h0);

    // Channel down: strobes must be ignored
    for (int i = 0; i < 3; i++) begin
      repeat (200) step();
      pulse();
    end
    repeat (5) step();
    check("chdown_log", log_d.size(), 0);

    // First burst, always ready
    chup = 1'b1;
    step();
    clear_log();
    pulse();
    wait_idle(100);
    check("b1_count", log_d.size(), 8);
`ifdef WRITE_BPM_TEST_LINK_LFSR_EN
    lit1 = '{32'hA5BE0000, 32'h1, 32'hFFFFFFFE, 32'h0, 32'hA5BE0001, 32'h1, 32'hFFFFFFFE, 32'h00400000};
`else
    lit1 = '{32'hA5BE0000, 32'h0, 32'hFFFFFFFF, 32'h0, 32'hA5BE0001, 32'h0, 32'hFFFFFFFF, 32'h00400000};
`endif
    if (log_d.size() == 8) begin
      for (int i = 0; i < 8; i++) begin
        check($sformatf("b1_w%0d", i), log_d[i], lit1[i]);
        check($sformatf("b1_last%0d", i), {31'b0, log_l[i]}, {31'b0, (i == 3 || i == 7)});
      end
    end

    // Second burst
    clear_log();
    pulse();
    wait_idle(100);
    check("b2_count", log_d.size(), 8);
    if (log_d.size() == 8) begin
`ifdef WRITE_BPM_TEST_LINK_LFSR_EN
      check("b2_x", log_d[1], 32'h80200003);
      check("b2_y", log_d[2], 32'h7FDFFFFC);
`else
      check("b2_x", log_d[1], 32'h1);
      check("b2_y", log_d[2], 32'hFFFFFFFE);
`endif
      check("b2_s1", log_d[7], 32'h00400001);
    end

    // Random backpressure with a strobe dropped mid-burst
    rand_rdy = 1'b1;
    for (int k = 0; k < 3; k++) begin
      clear_log();
      pulse();
      repeat (4) step();
      if (busy) pulse();
      wait_idle(400);
      nlast = 0;
      foreach (log_l[i]) nlast += int'(log_l[i]);
      check($sformatf("rnd%0d_count", k), log_d.size(), 8);
      check($sformatf("rnd%0d_tlast", k), nlast, 2);
      repeat (3) step();
    end
    rand_rdy = 1'b0;
    tready_r = 1'b1;
    step();

    // Channel drop after three transfers
    clear_log();
    pulse();
    for (int n = 0; n < 50 && log_d.size() < 3; n++) step();
    chup = 1'b0;
    step();
    check("abort_tvalid", {31'b0, bus.tvalid}, 32'h0);
    check("abort_tlast", {31'b0, bus.tlast}, 32'h0);
    repeat (3) step();
    chup = 1'b1;
    step();
    clear_log();
    pulse();
    wait_idle(100);
    check("post_count", log_d.size(), 8);
    if (log_d.size() == 8) begin
      check("post_w0", log_d[0], 32'hA5BE0000);
`ifndef WRITE_BPM_TEST_LINK_LFSR_EN
      check("post_x", log_d[1], 32'h6);
`endif
      check("post_y", log_d[2], ~log_d[1]);
      check("post_s1", log_d[7], 32'h00400006);
    end

    // Reset mid-burst
    pulse();
    repeat (2) step();
    rst = 1'b1;
    step();
    check("midrst_tvalid", {31'b0, bus.tvalid}, 32'h0);
    check("midrst_tdata", bus.tdata, 32'h0);
    rst = 1'b0;
    repeat (2) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1);
  end

endmodule
